// File: rtl/instr_mem_responder.sv
// Instruction memory with a preload port and a fixed-latency fetch response pipeline.
// Each fetch is answered LATENCY cycles later with the word, or with a NOP plus err if the fetch is illegal.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_mem_req_i,
  input  logic [31:0] instr_mem_addr_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] instr_mem_rd_data_o,
  output logic        instr_mem_rvalid_o,
  output logic        instr_mem_err_o,
  output logic [31:0] req_count_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]                mem_q [DEPTH_WORDS];
  logic [LATENCY-1:0]         vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0]         err_pipe_q, err_pipe_d;
  logic [LATENCY-1:0][31:0]   data_pipe_q, data_pipe_d;
  logic [31:0]                req_count_q, req_count_d;

  logic [31:0]      rd_word_off, ld_word_off;
  logic             rd_misaligned, rd_in_range, ld_in_range;
  logic [IDX_W-1:0] rd_idx, ld_idx;

  // An address below BASE_ADDR wraps to a huge offset, so one upper-bits test covers both ends.
  always_comb begin
    rd_word_off   = (instr_mem_addr_i - BASE_ADDR) >> 2;
    ld_word_off   = (load_addr_i - BASE_ADDR) >> 2;
    rd_misaligned = |instr_mem_addr_i[1:0];
    rd_in_range   = (rd_word_off >> IDX_W) == 32'd0;
    ld_in_range   = (ld_word_off >> IDX_W) == 32'd0;
    rd_idx        = rd_word_off[IDX_W-1:0];
    ld_idx        = ld_word_off[IDX_W-1:0];
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    err_pipe_d  = err_pipe_q;
    data_pipe_d = data_pipe_q;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      err_pipe_d[i]  = err_pipe_q[i-1];
      data_pipe_d[i] = data_pipe_q[i-1];
    end
    vld_pipe_d[0]  = instr_mem_req_i;
    err_pipe_d[0]  = 1'b0;
    data_pipe_d[0] = 32'h0;
    if (instr_mem_req_i) begin
      if (rd_misaligned || !rd_in_range) begin
        err_pipe_d[0]  = 1'b1;
        data_pipe_d[0] = NOP;
      end else begin
        data_pipe_d[0] = mem_q[rd_idx];
      end
    end
    req_count_d = req_count_q + {31'b0, instr_mem_req_i};
  end

  // Memory has no reset: contents survive reset and preloads land even while reset is high.
  always_ff @(posedge clk) begin
    if (load_we_i && ld_in_range) mem_q[ld_idx] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      err_pipe_q  <= '0;
      data_pipe_q <= '0;
      req_count_q <= 32'h0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      err_pipe_q  <= err_pipe_d;
      data_pipe_q <= data_pipe_d;
      req_count_q <= req_count_d;
    end
  end

  assign instr_mem_rd_data_o = data_pipe_q[LATENCY-1];
  assign instr_mem_rvalid_o  = vld_pipe_q[LATENCY-1];
  assign instr_mem_err_o     = err_pipe_q[LATENCY-1];
  assign req_count_o         = req_count_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: two responders (latency 2 and 3) share one stimulus stream and are
// checked every cycle against a word-array reference model.
module tb_instr_mem_responder;
  localparam int          NI    = 2;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        known;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset, req, we;
  logic [31:0] addr, laddr, ldata;
  logic [NI-1:0][31:0] rd, cnt;
  logic [NI-1:0]       rv, er;

  exp_t        sbq [NI][$];
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];
  logic [31:0] exp_cnt [NI];
  int          lat [NI];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (
    .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata),
    .instr_mem_rd_data_o(rd[0]), .instr_mem_rvalid_o(rv[0]),
    .instr_mem_err_o(er[0]), .req_count_o(cnt[0]));

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
    .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata),
    .instr_mem_rd_data_o(rd[1]), .instr_mem_rvalid_o(rv[1]),
    .instr_mem_err_o(er[1]), .req_count_o(cnt[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, want);
    end
  endtask

  // One cycle of stimulus; the expected response is computed from the model before this cycle's preload.
  task automatic drive(input bit r, input logic [31:0] a, input bit w,
                       input logic [31:0] la, input logic [31:0] ld, input bit rst);
    exp_t e;
    logic [31:0] off;
    @(posedge clk); #1;
    reset = rst; req = r; addr = a; we = w; laddr = la; ldata = ld;
    if (r && !rst) begin
      e.known = 1'b1; e.err = 1'b0; e.data = 32'h0;
      off = a - BASE;
      if (a[1:0] != 2'b00 || off >= 32'(4*DEPTH)) begin
        e.err = 1'b1; e.data = 32'h0000_0013;
      end else begin
        e.data = mem_m[off/4]; e.known = known[off/4];
      end
      for (int i = 0; i < NI; i++) begin
        e.due = cyc + lat[i];
        sbq[i].push_back(e);
      end
    end
    if (w) begin
      off = la - BASE;
      if (off < 32'(4*DEPTH)) begin
        mem_m[off/4] = ld; known[off/4] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        if (rv[i] === 1'b1) begin
          if (sbq[i].size() == 0 || sbq[i][0].due != cyc) begin
            chk($sformatf("u%0d_spurious_rvalid", i), 32'(rv[i]), 32'h0);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("u%0d_err", i), 32'(er[i]), 32'(e.err));
            if (e.known) chk($sformatf("u%0d_data", i), rd[i], e.data);
          end
        end else begin
          if (sbq[i].size() != 0 && sbq[i][0].due == cyc)
            chk($sformatf("u%0d_missing_rvalid", i), 32'(rv[i]), 32'h1);
          chk($sformatf("u%0d_idle_err", i), 32'(er[i]), 32'h0);
          chk($sformatf("u%0d_idle_data", i), rd[i], 32'h0);
        end
        chk($sformatf("u%0d_req_count", i), cnt[i], exp_cnt[i]);
        if (reset) begin
          sbq[i].delete();
          exp_cnt[i] = 32'h0;
        end else if (req) begin
          exp_cnt[i] = exp_cnt[i] + 32'h1;
        end
      end
    end
  end

  initial begin
    logic [31:0] a, la;
    lat[0] = 2; lat[1] = 3;
    exp_cnt[0] = 32'h0; exp_cnt[1] = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; laddr = 32'h0; ldata = 32'h0;

    // Preload during reset, then reset outputs are checked from the second reset cycle on.
    drive(0, 32'h0, 1, 32'd0,  32'h0050_0093, 1);
    drive(0, 32'h0, 1, 32'd4,  32'h00A0_0113, 1);
    mon_en = 1'b1;
    drive(0, 32'h0, 1, 32'd8,  32'h0020_81B3, 1);
    drive(0, 32'h0, 1, 32'd12, 32'h0000_006F, 1);
    drive(0, 32'h0, 1, 32'd16, 32'h0000_0013, 0);

    // Back-to-back fetch of words 0..3
    for (int k = 0; k < 4; k++) drive(1, 32'(4*k), 0, 32'h0, 32'h0, 0);
    idle(4);

    // Misaligned and out-of-range fetches
    drive(1, 32'h0000_0002, 0, 32'h0, 32'h0, 0);
    drive(1, 32'(4*DEPTH),  0, 32'h0, 32'h0, 0);
    drive(1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    drive(1, 32'(4*DEPTH+1), 0, 32'h0, 32'h0, 0);
    idle(4);

    // Bubble in the middle
    drive(1, 32'd0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'd4, 0, 32'h0, 32'h0, 0);
    drive(1, 32'd8, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Read-before-write on word 4, then the new value
    drive(1, 32'd16, 1, 32'd16, 32'hDEAD_BEEF, 0);
    drive(1, 32'd16, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Out-of-range preload must not alias onto word 0
    drive(0, 32'h0, 1, 32'(4*DEPTH), 32'hBAD0_BAD0, 0);
    drive(1, 32'd0, 0, 32'h0, 32'h0, 0);
    idle(4);

    // Reset one cycle after a request: that response must never appear
    drive(1, 32'd4, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1);
    drive(1, 32'd8, 0, 32'h0, 32'h0, 1);
    idle(5);
    for (int k = 0; k < 5; k++) drive(1, 32'(4*k), 0, 32'h0, 32'h0, 0);
    idle(4);

    // Randomized traffic with preloads and occasional resets
    for (int k = 0; k < 400; k++) begin
      a = $urandom_range(0, 4*DEPTH + 31);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      la = $urandom_range(0, 4*DEPTH + 31);
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0, la, $urandom,
            $urandom_range(0, 49) == 0);
    end
    idle(5);

    // Counter wrap: jump near the top, then three requests land on 1
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; reset = 1'b0;
    force u_l2.req_count_q = 32'hFFFF_FFFE;
    force u_l3.req_count_q = 32'hFFFF_FFFE;
    exp_cnt[0] = 32'hFFFF_FFFE; exp_cnt[1] = 32'hFFFF_FFFE;
    #2;
    release u_l2.req_count_q;
    release u_l3.req_count_q;
    for (int k = 0; k < 3; k++) drive(1, 32'(4*k), 0, 32'h0, 32'h0, 0);
    idle(1);
    @(negedge clk); #1;
    chk("wrap_count_l2", cnt[0], 32'h1);
    chk("wrap_count_l3", cnt[1], 32'h1);
    idle(5);

    for (int i = 0; i < NI; i++) chk($sformatf("u%0d_sb_drained", i), 32'(sbq[i].size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning: number of 32-bit instruction words; power of two, 16..65536.
REQ-002 Parameter LATENCY, default 2, meaning: cycles from request to response; legal 1..4.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, meaning: byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 instr_mem_req_i  input  1  fetch request valid this cycle.
REQ-008 instr_mem_addr_i  input  32  byte address of the requested instruction.
REQ-009 load_we_i  input  1  preload write enable.
REQ-010 load_addr_i  input  32  preload byte address; bits [1:0] ignored.
REQ-011 load_data_i  input  32  preload write data.
REQ-012 instr_mem_rd_data_o  output  32  response instruction word.
REQ-013 instr_mem_rvalid_o  output  1  response valid.
REQ-014 instr_mem_err_o  output  1  response is an error; qualified by rvalid.
REQ-015 req_count_o  output  32  number of accepted requests.

Function
REQ-016 Every cycle with instr_mem_req_i=1 and reset=0 accepts one request; no backpressure; back-to-back requests every cycle are sustained.
REQ-017 An accepted request produces exactly one response exactly LATENCY cycles later, in request order.
REQ-018 Responses sit in a LATENCY-deep shift pipeline; each stage holds valid, err and data; one stage advances per cycle.
REQ-019 Word index = (instr_mem_addr_i - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check.
REQ-020 Range check: address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS - 1] gives err=1 and data 32'h0000_0013 (NOP).
REQ-021 Alignment check: instr_mem_addr_i[1:0] != 2'b00 gives err=1 and data 32'h0000_0013; alignment is checked before range.
REQ-022 A legal request gives err=0 and data = memory word at the index, sampled in the acceptance cycle.
REQ-023 Cycles with instr_mem_req_i=0 insert a bubble; the matching output cycle has rvalid=0, err=0 and rd_data=32'h0000_0000.
REQ-024 A preload write with in-range load_addr_i updates the word at the clock edge; an out-of-range preload write is dropped silently.
REQ-025 Read and preload write to the same word in the same cycle: the read returns the old data (read-before-write).
REQ-026 A preload write never disturbs responses already in the pipeline.
REQ-027 req_count_o increments by 1 per accepted request, including error requests, and wraps from 32'hFFFF_FFFF to 0.
REQ-028 Memory contents are not initialised by the block; unwritten words are undefined to the bench.

Reset
REQ-029 While reset=1: all pipeline valids clear; rvalid=0, err=0, rd_data=32'h0, req_count_o=0 from the next edge.
REQ-030 A request presented during reset is not accepted and not counted; in-flight responses are discarded with no partial output.
REQ-031 Memory contents survive reset; a preload write during reset still takes effect.
REQ-032 The first request after reset deasserts is accepted in that cycle; its response appears LATENCY cycles later.

Verification
REQ-033 Preload words 0..3 with 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F; req held high with addr 0,4,8,12 on consecutive cycles, LATENCY=2 -> rvalid=1 on cycles 2..5 with those four words in order, err=0.
REQ-034 Request addr 32'h0000_0002 -> response after LATENCY cycles: rvalid=1, err=1, data 32'h0000_0013; request addr 4*DEPTH_WORDS -> same error response.
REQ-035 req pattern 1,0,1 at addr 0,x,8 -> rvalid pattern 1,0,1 with word0 and word2; the bubble cycle shows data 32'h0.
REQ-036 Same cycle: read addr 16 and preload addr 16 with 32'hDEADBEEF over an old value of 32'h00000013 -> response 32'h00000013; next read of addr 16 -> 32'hDEADBEEF.
REQ-037 Reset asserted one cycle after a request with LATENCY=3 -> no rvalid ever appears for that request; req_count_o=0; preloaded words are unchanged afterwards.
REQ-038 Force req_count_o near wrap (2^32-2 via 2^32-2 requests or a bench-only shortened parameter) plus 3 requests -> req_count_o reads 32'h1.
